mips_regfile_mp: RTL and testbench
==================================

// Module: mips_regfile_mp
// PURPOSE
//  Parametrised multi-port GPR file for the MIPS core; successor of the single-write 2-read file.
//  Adds: NUM_RD read ports, two write ports (WB + late load), hardwired-zero r0, async reset clear,
//  write-to-read bypass, per-register busy scoreboard for load-use hazard detection.
//  Sits between decode (reads, reserve) and writeback (writes, release).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register address width; DEPTH = 2**ADDR_W entries
//  NUM_RD   2   number of read ports (1..4)
//  ZERO_REG 1   1: entry 0 reads 0, writes/reservations to it ignored; 0: entry 0 is ordinary
//  BYPASS   1   1: same-cycle write data forwarded to matching read; 0: reads return stored value
// PORTS
//  clk         in   1              clock, all state updates on rising edge
//  rst         in   1              asynchronous, active-high reset
//  rf_addr_r   in   NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rf_data_r   out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
//  rf_busy_r   out  NUM_RD         busy bit of addressed register, per read port
//  rf_wen0     in   1              write port 0 enable (ALU writeback)
//  rf_addr_w0  in   ADDR_W         write port 0 address
//  rf_data_w0  in   DATA_W         write port 0 data
//  rf_wen1     in   1              write port 1 enable (load return)
//  rf_addr_w1  in   ADDR_W         write port 1 address
//  rf_data_w1  in   DATA_W         write port 1 data
//  rf_rsv      in   1              reserve: mark rf_addr_rsv busy (load issued)
//  rf_addr_rsv in   ADDR_W         register to reserve
//  rf_busy_any out  1              OR of all busy bits (pipeline drain indicator)
// BEHAVIOUR
//  Reset (async, rst=1): all entries <= 0, all busy bits <= 0; rf_data_r = 0, rf_busy_r = 0,
//   rf_busy_any = 0 while rst held. Writes/reserves ignored during reset; first edge after release acts.
//  Read: combinational, zero latency. Entry 0 with ZERO_REG=1 -> data 0, busy 0 regardless of bypass.
//  Write: rising edge, rf_wenX=1 -> file[rf_addr_wX] <= rf_data_wX. Both ports same address: port 1 wins.
//  Bypass (BYPASS=1): read addr == enabled write addr -> rf_data_r returns write data same cycle;
//   both writes match -> port 1 data. BYPASS=0 -> old value until after the edge.
//  Scoreboard: busy[i] set on edge when rf_rsv & rf_addr_rsv==i; cleared on edge when write port 1
//   writes i. Port 0 writes do NOT clear busy. Same-edge set and clear of i -> set wins (newer load).
//  rf_busy_r[k] = busy[rf_addr_r[k]] registered state; no bypass of reserve/release onto busy.
//  ZERO_REG=1: write or reserve to entry 0 has no effect; busy[0] stays 0.
//  Reset mid-operation: pending reservations discarded; no write completes on the reset edge.
//  No X propagation: out-of-range addresses impossible (DEPTH = 2**ADDR_W).
// STRUCTURE
//  Shared package mips_pkg: REG_W=32, REG_AW=5, REG_ZERO=5'd0 constants, typedef reg_addr_t.
//  Sub-module rf_scoreboard (busy vector, set/clear priority, per-port lookup, OR-reduce);
//  storage, write priority and bypass muxes in top via generate over NUM_RD.
// TESTING
//  Reset: write 0x1234 to r5, pulse rst mid-cycle -> r5 reads 0 immediately, rf_busy_any=0.
//  Zero reg: write 0xFFFF_FFFF to r0 on both ports, reserve r0 -> reads 0, rf_busy_r=0.
//  Dual write collision: w0 r7=0xAAAA, w1 r7=0x5555 same edge -> r7 reads 0x5555 next cycle.
//  Bypass: w0 r3=0xDEAD, read r3 same cycle -> 0xDEAD (BYPASS=1), old value 0 (BYPASS=0 build).
//  Scoreboard: reserve r9 -> busy next cycle; w0 r9 -> still busy; w1 r9 -> clear next cycle;
//   reserve r9 and w1 r9 same edge -> busy stays 1, data updated.
//  Ports: NUM_RD=4, read r1..r4 after writes 1..4 -> each port returns its value simultaneously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core register file.
package mips_pkg;
    localparam int REG_W  = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for load-use hazard detection: a load reserves its
// destination at issue, and the load-return write port releases it.
module rf_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_set,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic                     i_clr,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_busy_r,
    output logic                     o_busy_any
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic             w_set_ok;

    assign w_set_ok = i_set && !((ZERO_REG != 0) && (i_set_addr == '0));

    // Set is applied after clear so a new load reserving the register wins
    // over the release of the previous load on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr)
                r_busy[i_clr_addr] <= 1'b0;
            if (w_set_ok)
                r_busy[i_set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        assign o_busy_r[k] = r_busy[i_rd_addr[k*ADDR_W +: ADDR_W]];
    end

    assign o_busy_any = |r_busy;
endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational read ports, two write ports
// (ALU writeback and late load return), optional r0 hardwire and bypass.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int ADDR_W   = REG_AW,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rf_addr_r,
    output logic [NUM_RD*DATA_W-1:0] rf_data_r,
    output logic [NUM_RD-1:0]        rf_busy_r,
    input  logic                     rf_wen0,
    input  logic [ADDR_W-1:0]        rf_addr_w0,
    input  logic [DATA_W-1:0]        rf_data_w0,
    input  logic                     rf_wen1,
    input  logic [ADDR_W-1:0]        rf_addr_w1,
    input  logic [DATA_W-1:0]        rf_data_w1,
    input  logic                     rf_rsv,
    input  logic [ADDR_W-1:0]        rf_addr_rsv,
    output logic                     rf_busy_any
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_file [DEPTH];
    logic              w_we0;
    logic              w_we1;

    assign w_we0 = rf_wen0 && !((ZERO_REG != 0) && (rf_addr_w0 == '0));
    assign w_we1 = rf_wen1 && !((ZERO_REG != 0) && (rf_addr_w1 == '0));

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_file[i] <= '0;
        end else begin
            if (w_we0)
                r_file[rf_addr_w0] <= rf_data_w0;
            if (w_we1)
                r_file[rf_addr_w1] <= rf_data_w1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = rf_addr_r[k*ADDR_W +: ADDR_W];

        // Forwarding is suppressed while reset is held so reads stay zero.
        always_comb begin
            w_rd = r_file[w_ra];
            if ((BYPASS != 0) && !rst) begin
                if (w_we1 && (rf_addr_w1 == w_ra))
                    w_rd = rf_data_w1;
                else if (w_we0 && (rf_addr_w0 == w_ra))
                    w_rd = rf_data_w0;
            end
            if ((ZERO_REG != 0) && (w_ra == '0))
                w_rd = '0;
        end

        assign rf_data_r[k*DATA_W +: DATA_W] = w_rd;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set      (rf_rsv),
        .i_set_addr (rf_addr_rsv),
        .i_clr      (w_we1),
        .i_clr_addr (rf_addr_w1),
        .i_rd_addr  (rf_addr_r),
        .o_busy_r   (rf_busy_r),
        .o_busy_any (rf_busy_any)
    );
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: directed vector table, hand-written reset
// sequence and random traffic against an array-based reference model.
module tb_mips_regfile_mp;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rf_addr_r;
    logic [NR*DW-1:0] rf_data_r;
    logic [NR-1:0]    rf_busy_r;
    logic             rf_wen0, rf_wen1, rf_rsv;
    logic [AW-1:0]    rf_addr_w0, rf_addr_w1, rf_addr_rsv;
    logic [DW-1:0]    rf_data_w0, rf_data_w1;
    logic             rf_busy_any;
    logic [DW-1:0]    nb_data;
    logic             nb_busy;
    logic             nb_busy_any;

    always #5 clk = ~clk;

    mips_regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rf_addr_r(rf_addr_r), .rf_data_r(rf_data_r), .rf_busy_r(rf_busy_r),
        .rf_wen0(rf_wen0), .rf_addr_w0(rf_addr_w0), .rf_data_w0(rf_data_w0),
        .rf_wen1(rf_wen1), .rf_addr_w1(rf_addr_w1), .rf_data_w1(rf_data_w1),
        .rf_rsv(rf_rsv), .rf_addr_rsv(rf_addr_rsv), .rf_busy_any(rf_busy_any)
    );

    // Second build: single read port, no bypass, r0 ordinary; shares the write side.
    mips_regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)
    ) u_nb (
        .clk(clk), .rst(rst),
        .rf_addr_r(rf_addr_r[AW-1:0]), .rf_data_r(nb_data), .rf_busy_r(nb_busy),
        .rf_wen0(rf_wen0), .rf_addr_w0(rf_addr_w0), .rf_data_w0(rf_data_w0),
        .rf_wen1(rf_wen1), .rf_addr_w1(rf_addr_w1), .rf_data_w1(rf_data_w1),
        .rf_rsv(rf_rsv), .rf_addr_rsv(rf_addr_rsv), .rf_busy_any(nb_busy_any)
    );

    typedef struct {
        logic            wen0;
        logic [AW-1:0]   a0;
        logic [DW-1:0]   d0;
        logic            wen1;
        logic [AW-1:0]   a1;
        logic [DW-1:0]   d1;
        logic            rsv;
        logic [AW-1:0]   arsv;
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] ed;
        logic [NR-1:0]   eb;
        logic            eany;
    } vec_t;

    vec_t tab[18];

    logic [DW-1:0] m_mem[32];
    logic          m_busy[32];
    logic [DW-1:0] m_nb_mem[32];
    logic          m_nb_busy[32];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] d0,
                                logic w1, logic [4:0] a1, logic [31:0] d1,
                                logic rv, logic [4:0] ar,
                                logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3,
                                logic [3:0] eb, logic eany);
        vec_t v;
        v.wen0 = w0; v.a0 = a0; v.d0 = d0;
        v.wen1 = w1; v.a1 = a1; v.d1 = d1;
        v.rsv = rv;  v.arsv = ar;
        v.ra = {r3, r2, r1, r0};
        v.ed = {e3, e2, e1, e0};
        v.eb = eb;   v.eany = eany;
        return v;
    endfunction

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        rf_wen0 = v.wen0; rf_addr_w0 = v.a0; rf_data_w0 = v.d0;
        rf_wen1 = v.wen1; rf_addr_w1 = v.a1; rf_data_w1 = v.d1;
        rf_rsv = v.rsv;   rf_addr_rsv = v.arsv;
        rf_addr_r = v.ra;
    endtask

    task automatic set_idle(input logic [NR*AW-1:0] ra);
        set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rf_addr_r = ra;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0; m_busy[i] = 1'b0;
            m_nb_mem[i] = '0; m_nb_busy[i] = 1'b0;
        end
    endtask

    // Reference read: r0 is zero, otherwise newest same-cycle write, else stored value.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == REG_ZERO) return '0;
        if (rf_wen1 && rf_addr_w1 == a) return rf_data_w1;
        if (rf_wen0 && rf_addr_w0 == a) return rf_data_w0;
        return m_mem[a];
    endfunction

    task automatic model_edge();
        if (rf_wen0 && rf_addr_w0 != REG_ZERO) m_mem[rf_addr_w0] = rf_data_w0;
        if (rf_wen1 && rf_addr_w1 != REG_ZERO) m_mem[rf_addr_w1] = rf_data_w1;
        if (rf_wen1) m_busy[rf_addr_w1] = 1'b0;
        if (rf_rsv && rf_addr_rsv != REG_ZERO) m_busy[rf_addr_rsv] = 1'b1;
        if (rf_wen0) m_nb_mem[rf_addr_w0] = rf_data_w0;
        if (rf_wen1) m_nb_mem[rf_addr_w1] = rf_data_w1;
        if (rf_wen1) m_nb_busy[rf_addr_w1] = 1'b0;
        if (rf_rsv) m_nb_busy[rf_addr_rsv] = 1'b1;
    endtask

    task automatic check_nb();
        logic any_nb;
        any_nb = 1'b0;
        for (int i = 0; i < 32; i++) any_nb |= m_nb_busy[i];
        check("nb_data", nb_data, m_nb_mem[rf_addr_r[AW-1:0]]);
        check("nb_busy", nb_busy, m_nb_busy[rf_addr_r[AW-1:0]]);
        check("nb_busy_any", nb_busy_any, any_nb);
    endtask

    task automatic check_model();
        logic [NR*DW-1:0] ed;
        logic [NR-1:0]    eb;
        logic             any;
        any = 1'b0;
        for (int i = 0; i < 32; i++) any |= m_busy[i];
        for (int k = 0; k < NR; k++) begin
            ed[k*DW +: DW] = model_read(rf_addr_r[k*AW +: AW]);
            eb[k] = (rf_addr_r[k*AW +: AW] == REG_ZERO) ? 1'b0 : m_busy[rf_addr_r[k*AW +: AW]];
        end
        check("rnd_data", rf_data_r, ed);
        check("rnd_busy", rf_busy_r, eb);
        check("rnd_busy_any", rf_busy_any, any);
        check_nb();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 3,  0, 0, 0, 0,  4'b0000, 0);
        tab[1]  = mk(1, 3, 32'hDEAD, 0, 0, 0, 0, 0,  3, 0, 0, 0,  32'hDEAD, 0, 0, 0,  4'b0000, 0);
        tab[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0,  32'hDEAD, 0, 0, 0,  4'b0000, 0);
        tab[3]  = mk(1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0,  7, 3, 0, 0,  32'h5555, 32'hDEAD, 0, 0,  4'b0000, 0);
        tab[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  7, 3, 0, 0,  32'h5555, 32'hDEAD, 0, 0,  4'b0000, 0);
        tab[5]  = mk(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0,  0, 0, 7, 0,  0, 0, 32'h5555, 0,  4'b0000, 0);
        tab[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 0,  0, 0, 32'h5555, 0,  4'b0000, 0);
        tab[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9,  9, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 0);
        tab[8]  = mk(1, 9, 32'h1111, 0, 0, 0, 0, 0,  9, 9, 0, 0,  32'h1111, 32'h1111, 0, 0,  4'b0011, 1);
        tab[9]  = mk(0, 0, 0, 1, 9, 32'h2222, 0, 0,  9, 0, 0, 9,  32'h2222, 0, 0, 32'h2222,  4'b1001, 1);
        tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  9, 9, 9, 9,  32'h2222, 32'h2222, 32'h2222, 32'h2222,  4'b0000, 0);
        tab[11] = mk(0, 0, 0, 1, 9, 32'h3333, 1, 9,  9, 0, 0, 0,  32'h3333, 0, 0, 0,  4'b0000, 0);
        tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  9, 0, 0, 0,  32'h3333, 0, 0, 0,  4'b0001, 1);
        tab[13] = mk(1, 1, 1, 1, 2, 2, 0, 0,  1, 2, 3, 4,  1, 2, 32'hDEAD, 0,  4'b0000, 1);
        tab[14] = mk(1, 3, 3, 1, 4, 4, 0, 0,  1, 2, 3, 4,  1, 2, 3, 4,  4'b0000, 1);
        tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 3, 4,  1, 2, 3, 4,  4'b0000, 1);
        tab[16] = mk(0, 0, 0, 1, 9, 0, 0, 0,  9, 1, 0, 0,  0, 1, 0, 0,  4'b0001, 1);
        tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  9, 1, 0, 0,  0, 1, 0, 0,  4'b0000, 0);

        rst = 1'b1;
        set_idle('0);
        model_reset();
        #1;
        check("reset_data", rf_data_r, '0);
        check("reset_busy", rf_busy_r, '0);
        check("reset_busy_any", rf_busy_any, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            set_in(tab[i]);
            #2;
            check($sformatf("vec%0d_data", i), rf_data_r, tab[i].ed);
            check($sformatf("vec%0d_busy", i), rf_busy_r, tab[i].eb);
            check($sformatf("vec%0d_busy_any", i), rf_busy_any, tab[i].eany);
            check_nb();
            step();
        end

        // Reset in mid-cycle with a write in flight and a reservation pending.
        set_in(mk(1, 5, 32'h1234, 0, 0, 0, 1, 6,  5, 6, 0, 0,  0, 0, 0, 0,  0, 0));
        step();
        set_idle({5'd0, 5'd0, 5'd6, 5'd5});
        #2;
        check("pre_rst_r5", rf_data_r[DW-1:0], 32'h1234);
        check("pre_rst_busy_any", rf_busy_any, 1'b1);
        rf_wen0 = 1'b1; rf_addr_w0 = 5'd5; rf_data_w0 = 32'hBEEF;
        rf_rsv = 1'b1;  rf_addr_rsv = 5'd7;
        rst = 1'b1;
        #1;
        check("rst_r5_zero", rf_data_r, '0);
        check("rst_busy_any", rf_busy_any, 1'b0);
        check("rst_busy_r", rf_busy_r, '0);
        check("rst_nb_zero", nb_data, '0);
        @(posedge clk);
        #1;
        model_reset();
        check("rst_edge_no_write", rf_data_r, '0);
        check("rst_edge_no_rsv", rf_busy_any, 1'b0);
        rst = 1'b0;
        rf_rsv = 1'b0;
        #2;
        check("post_rst_bypass", rf_data_r[DW-1:0], 32'hBEEF);
        check("post_rst_nb_old", nb_data, '0);
        step();
        set_idle({5'd0, 5'd0, 5'd6, 5'd5});
        #2;
        check("post_rst_r5", rf_data_r[DW-1:0], 32'hBEEF);
        check("post_rst_busy_any", rf_busy_any, 1'b0);
        check_model();
        step();

        // Random traffic on a narrowed address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            rf_wen0 = ($urandom_range(0, 1) == 1);
            rf_addr_w0 = 5'($urandom_range(0, 15));
            rf_data_w0 = $urandom;
            rf_wen1 = ($urandom_range(0, 2) == 0);
            rf_addr_w1 = 5'($urandom_range(0, 15));
            rf_data_w1 = $urandom;
            rf_rsv = ($urandom_range(0, 2) == 0);
            rf_addr_rsv = 5'($urandom_range(0, 15));
            for (int k = 0; k < NR; k++)
                rf_addr_r[k*AW +: AW] = 5'($urandom_range(0, 15));
            #2;
            check_model();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
